// File: rtl/apb_sl_regfile.sv
// apb_sl_regfile
//   APB3 slave register file sitting between the system bus and the SL
//   (SL0/SL1) transceiver core. Zero-wait-state bus, TX valid/ready
//   handshake, RX FIFO, sticky error flags and a registered interrupt.
//
// Ports
//   clk, rst_n                   clock (posedge), async active-low reset
//   psel_a, penable_a, pwrite_a  APB control
//   paddr_a, pwdata_a            APB address / write data
//   prdata_a, pready_a,          APB read data / completion / error
//   pslverr_a
//   cfg_o                        config to core: [0] PCE [6:1] BQ [7] MODE [8] IRQM
//   tx_data_o, tx_valid_o,       word to SL transmitter with handshake
//   tx_ready_i
//   rx_data_i, rx_valid_i        received word and its push strobe
//   rx_perr_i, line_err_i        receiver parity / line error pulses
//   irq_o                        interrupt request
//
// Register map (paddr_a[4:2])
//   0 CONFIG  R/W
//   1 STATUS  R, W1C on sticky bits [5:3]
//   2 TX_DATA W
//   3 RX_DATA R, read pops the FIFO

module apb_sl_regfile #(
  parameter int DATA_W   = 32,
  parameter int CFG_W    = 16,
  parameter int RX_DEPTH = 4,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel_a,
  input  logic              penable_a,
  input  logic              pwrite_a,
  input  logic [ADDR_W-1:0] paddr_a,
  input  logic [DATA_W-1:0] pwdata_a,
  output logic [DATA_W-1:0] prdata_a,
  output logic              pready_a,
  output logic              pslverr_a,
  output logic [CFG_W-1:0]  cfg_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  input  logic              rx_perr_i,
  input  logic              line_err_i,
  output logic              irq_o
);

  localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RX_DEPTH);

  localparam logic [2:0] OFF_CONFIG = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_TX     = 3'd2;
  localparam logic [2:0] OFF_RX     = 3'd3;

  logic              setup, access;
  logic [2:0]        off;
  logic              acc_err, wr_ok, rd_ok;
  logic              cfg_we, stat_we, tx_we, pop, push_ok, ovf_set;

  logic [CFG_W-1:0]  cfg_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  rx_cnt;
  logic              rx_ne, rx_full;
  logic              ovf_q, pef_q, lef_q, irq_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] status, rd_mux;

  // Address LSBs and the high address/data bits are don't-care by design.
  logic unused_bits;
  assign unused_bits = ^{paddr_a, pwdata_a};

  assign setup  = psel_a & ~penable_a;
  assign access = psel_a & penable_a;
  assign off    = paddr_a[4:2];

  assign rx_ne   = (rx_cnt != '0);
  assign rx_full = (rx_cnt == CNT_FULL);

  // Access-phase error decode; TX busy is sampled here, not at setup.
  always_comb begin
    acc_err = 1'b0;
    case (off)
      OFF_CONFIG: acc_err = 1'b0;
      OFF_STATUS: acc_err = 1'b0;
      OFF_TX:     acc_err = ~pwrite_a | tx_valid_q;
      OFF_RX:     acc_err = pwrite_a;
      default:    acc_err = 1'b1;
    endcase
  end

  assign wr_ok   = access & pwrite_a & ~acc_err;
  assign rd_ok   = access & ~pwrite_a & ~acc_err;
  assign cfg_we  = wr_ok & (off == OFF_CONFIG);
  assign stat_we = wr_ok & (off == OFF_STATUS);
  assign tx_we   = wr_ok & (off == OFF_TX);
  assign pop     = rd_ok & (off == OFF_RX) & rx_ne;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = rx_valid_i & (~rx_full | pop);
  assign ovf_set = rx_valid_i & rx_full & ~pop;

  always_comb begin
    status        = '0;
    status[0]     = tx_valid_q;
    status[1]     = rx_ne;
    status[2]     = rx_full;
    status[3]     = ovf_q;
    status[4]     = pef_q;
    status[5]     = lef_q;
    status[15:8]  = 8'(rx_cnt);
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CONFIG: rd_mux[CFG_W-1:0] = cfg_q;
      OFF_STATUS: rd_mux = status;
      OFF_RX:     rd_mux = rx_ne ? rx_mem[rd_ptr] : '0;
      default:    rd_mux = '0;
    endcase
  end

  // Read data is captured at setup so STATUS/RX head reflect pre-access state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_q <= '0;
    else if (setup) rd_q <= pwrite_a ? '0 : rd_mux;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cfg_q <= '0;
    else if (cfg_we) cfg_q <= pwdata_a[CFG_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else if (tx_we) begin
      tx_data_q  <= pwdata_a;
      tx_valid_q <= 1'b1;
    end else if (tx_valid_q & tx_ready_i) begin
      tx_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) rx_mem[wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      rx_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as a W1C wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      pef_q <= 1'b0;
      lef_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set    | (ovf_q & ~(stat_we & pwdata_a[3]));
      pef_q <= rx_perr_i  | (pef_q & ~(stat_we & pwdata_a[4]));
      lef_q <= line_err_i | (lef_q & ~(stat_we & pwdata_a[5]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= cfg_q[8] ? rx_ne : (rx_ne | ovf_q | pef_q | lef_q);
  end

  assign pready_a   = access;
  assign pslverr_a  = access & acc_err;
  assign prdata_a   = rd_ok ? rd_q : '0;
  assign cfg_o      = cfg_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign irq_o      = irq_q;

endmodule
